// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM for the 64-bit RISC-V datapath (ld, sd, add/sub/and/or, addi, beq).
// Outputs are decoded from the state; only ir_write, pc_write and instr_done also look at mem_ready/zero.
//
// state    | meaning
// IDLE     | post-reset, one dead cycle
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | precompute branch target old_pc + B-imm into ALUOut
// MEM_ADDR | rs1 + I/S immediate for ld/sd
// MEM_RD   | load data read, wait on mem_ready
// WB_MEM   | write MDR into rd
// MEM_WR   | store data write, wait on mem_ready
// EXEC_R   | R-type ALU op, rejects unknown funct7/funct3
// EXEC_I   | addi
// WB_R     | write ALUOut into rd
// BRANCH   | beq compare, PC <= ALUOut when zero
// ILLEGAL  | unsupported encoding, skip it
module riscv_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  imm_sel,
    output logic        instr_done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        WB_MEM   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        EXEC_I   = 4'd8,
        WB_R     = 4'd9,
        BRANCH   = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    state_t      state;
    state_t      next_state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        r_legal;
    logic        unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^instruction[24:15] ^ ^instruction[11:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 4'b0000;
        imm_sel    = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        r_legal    = 1'b1;

        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                imm_sel   = IMM_B;
                alu_ctrl  = ALU_ADD;
                if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == 3'b011)
                    next_state = MEM_ADDR;
                else if (opcode == OP_REG)
                    next_state = EXEC_R;
                else if (opcode == OP_IMM && funct3 == 3'b000)
                    next_state = EXEC_I;
                else if (opcode == OP_BR && funct3 == 3'b000)
                    next_state = BRANCH;
                else
                    next_state = ILLEGAL;
            end
            MEM_ADDR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                alu_ctrl   = ALU_ADD;
                imm_sel    = (opcode == OP_LOAD) ? IMM_I : IMM_S;
                next_state = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next_state = WB_MEM;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) next_state = FETCH;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                case ({funct7, funct3})
                    10'b0000000_000: alu_ctrl = ALU_ADD;
                    10'b0100000_000: alu_ctrl = ALU_SUB;
                    10'b0000000_111: alu_ctrl = ALU_AND;
                    10'b0000000_110: alu_ctrl = ALU_OR;
                    default:         r_legal  = 1'b0;
                endcase
                next_state = r_legal ? WB_R : ILLEGAL;
            end
            EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                imm_sel    = IMM_I;
                alu_ctrl   = ALU_ADD;
                next_state = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_ctrl   = ALU_SUB;
                pc_src     = 1'b1;
                pc_write   = zero;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            ILLEGAL: begin
                // PC already advanced in FETCH, so the bad word is simply skipped
                illegal    = 1'b1;
                next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: each instruction is expanded into a list of expected
// per-cycle control words (with memory-wait and zero-dependent bits) and checked cycle by cycle.
module tb_riscv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d;
    logic        reg_write, mem_to_reg, instr_done, illegal;
    logic [1:0]  alu_src_a, alu_src_b, imm_sel;
    logic [3:0]  alu_ctrl;
    logic [19:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_sel(imm_sel),
        .instr_done(instr_done), .illegal(illegal)
    );

    assign outs = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg,
                   alu_src_a, alu_src_b, alu_ctrl, imm_sel, instr_done, illegal};

    localparam logic [19:0] PCW  = 20'h80000;
    localparam logic [19:0] PCS  = 20'h40000;
    localparam logic [19:0] IRW  = 20'h20000;
    localparam logic [19:0] MR   = 20'h10000;
    localparam logic [19:0] MW   = 20'h08000;
    localparam logic [19:0] IOD  = 20'h04000;
    localparam logic [19:0] RW   = 20'h02000;
    localparam logic [19:0] M2R  = 20'h01000;
    localparam logic [19:0] DONE = 20'h00002;
    localparam logic [19:0] ILL  = 20'h00001;
    localparam logic [19:0] NONE = 20'h00000;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR  = 4'b0001;

    localparam logic [31:0] LD_X2 = 32'b00000000010011100011000100000011;

    function automatic logic [19:0] fa(input logic [1:0] v);   return {8'b0, v, 10'b0}; endfunction
    function automatic logic [19:0] fb(input logic [1:0] v);   return {10'b0, v, 8'b0}; endfunction
    function automatic logic [19:0] falu(input logic [3:0] v); return {12'b0, v, 4'b0}; endfunction
    function automatic logic [19:0] fimm(input logic [1:0] v); return {16'b0, v, 2'b0}; endfunction

    typedef struct {
        logic [19:0] base;
        logic [19:0] rdy;
        logic [19:0] zbit;
        bit          mem;
    } step_t;

    step_t steps[$];

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic void add_step(input logic [19:0] base, input bit mem,
                                     input logic [19:0] rdy, input logic [19:0] zb);
        step_t s;
        s.base = base; s.mem = mem; s.rdy = rdy; s.zbit = zb;
        steps.push_back(s);
    endfunction

    // Expected control-word sequence of one instruction, straight from the ISA subset rules
    function automatic void build(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] rop;
        bit         rok;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        steps.delete();
        add_step(MR | fa(2'b00) | fb(2'b01) | falu(ADD), 1'b1, IRW | PCW, NONE);
        add_step(fa(2'b01) | fb(2'b10) | fimm(2'b10) | falu(ADD), 1'b0, NONE, NONE);
        if (op == 7'b0000011 && f3 == 3'b011) begin
            add_step(fa(2'b10) | fb(2'b10) | falu(ADD) | fimm(2'b00), 1'b0, NONE, NONE);
            add_step(MR | IOD, 1'b1, NONE, NONE);
            add_step(RW | M2R | DONE, 1'b0, NONE, NONE);
        end else if (op == 7'b0100011 && f3 == 3'b011) begin
            add_step(fa(2'b10) | fb(2'b10) | falu(ADD) | fimm(2'b01), 1'b0, NONE, NONE);
            add_step(MW | IOD, 1'b1, DONE, NONE);
        end else if (op == 7'b0110011) begin
            rok = 1'b1; rop = 4'b0000;
            if (f7 == 7'b0000000 && f3 == 3'b000)      rop = ADD;
            else if (f7 == 7'b0100000 && f3 == 3'b000) rop = SUB;
            else if (f7 == 7'b0000000 && f3 == 3'b111) rop = AND;
            else if (f7 == 7'b0000000 && f3 == 3'b110) rop = OR;
            else rok = 1'b0;
            add_step(fa(2'b10) | fb(2'b00) | falu(rop), 1'b0, NONE, NONE);
            if (rok) add_step(RW | DONE, 1'b0, NONE, NONE);
            else     add_step(ILL, 1'b0, NONE, NONE);
        end else if (op == 7'b0010011 && f3 == 3'b000) begin
            add_step(fa(2'b10) | fb(2'b10) | fimm(2'b00) | falu(ADD), 1'b0, NONE, NONE);
            add_step(RW | DONE, 1'b0, NONE, NONE);
        end else if (op == 7'b1100011 && f3 == 3'b000) begin
            add_step(fa(2'b10) | fb(2'b00) | falu(SUB) | PCS | DONE, 1'b0, NONE, PCW);
        end else begin
            add_step(ILL, 1'b0, NONE, NONE);
        end
    endfunction

    // nwait < 0: random waits (max 4) per memory step; zmode 0/1 fixed zero, 2 random
    task automatic run_instr(input logic [31:0] ins, input int nwait, input int zmode, input string name);
        logic [19:0] exp;
        int          waited;
        bit          adv;
        build(ins);
        instruction = ins;
        for (int i = 0; i < steps.size(); i++) begin
            waited = 0;
            adv    = 1'b0;
            while (!adv) begin
                if (steps[i].mem) begin
                    if (nwait < 0) mem_ready = (waited >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    else           mem_ready = (waited >= nwait);
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
                exp = steps[i].base | ((steps[i].mem && mem_ready) ? steps[i].rdy : NONE)
                      | (zero ? steps[i].zbit : NONE);
                @(negedge clk);
                check($sformatf("%s.s%0d.w%0d", name, i, waited), outs, exp);
                adv = !steps[i].mem || mem_ready;
                waited++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 9);
        if (k == 0 || k == 1) begin
            r[6:0]   = (k == 0) ? 7'b0000011 : 7'b0100011;
            r[14:12] = ($urandom_range(0, 3) != 0) ? 3'b011 : 3'($urandom());
        end else if (k == 2 || k == 3) begin
            r[6:0] = 7'b0110011;
            case ($urandom_range(0, 2))
                0:       r[31:25] = 7'b0000000;
                1:       r[31:25] = 7'b0100000;
                default: r[31:25] = 7'($urandom());
            endcase
            r[14:12] = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'($urandom());
        end else if (k == 4 || k == 5) begin
            r[6:0]   = (k == 4) ? 7'b0010011 : 7'b1100011;
            r[14:12] = ($urandom_range(0, 3) != 0) ? 3'b000 : 3'($urandom());
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] exp;
        mem_ready   = 1'b1;
        zero        = 1'b1;
        instruction = 32'h00000033;
        #2 check("reset_hold", outs, NONE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk) check("idle", outs, NONE);
        @(posedge clk); #1;

        run_instr(LD_X2, 0, 2, "ld");
        run_instr({7'b0, 5'd5, 5'd10, 3'b011, 5'b01000, 7'b0100011}, 3, 2, "sd_wait3");
        run_instr(32'h402081B3, 0, 2, "sub");
        run_instr({7'b0, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011}, 1, 2, "and");
        run_instr({7'b0, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011}, 0, 2, "or");
        run_instr({7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 2, "add");
        run_instr({12'd5, 5'd1, 3'b000, 5'd3, 7'b0010011}, 0, 2, "addi");
        run_instr({7'b0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011}, 0, 1, "beq_z1");
        run_instr({7'b0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011}, 0, 0, "beq_z0");
        run_instr({25'h0, 7'b1111111}, 0, 2, "ill_op");
        run_instr({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 2, "ill_f7");

        // reset asserted while an ld waits in its memory read
        build(LD_X2);
        instruction = LD_X2;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            zero = 1'($urandom_range(0, 1));
            exp = steps[i].base | ((steps[i].mem && mem_ready) ? steps[i].rdy : NONE);
            @(negedge clk) check($sformatf("rst_ld.s%0d", i), outs, exp);
            @(posedge clk); #1;
        end
        check("rd_wait", outs, MR | IOD);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1 check("rst_async", outs, NONE);
        @(posedge clk); #1;
        check("rst_held", outs, NONE);
        rst_n = 1'b1;
        @(negedge clk) check("idle2", outs, NONE);
        @(posedge clk); #1;

        for (int n = 0; n < 200; n++) begin
            run_instr(rand_instr(), -1, 2, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
